// File: rtl/count_seq.sv
// Command sequencer for a down-counter: queues target values, loads and enables
// the counter for each one, and reports completion or a watchdog timeout.
module count_seq #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 2**WIDTH + 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_value,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [WIDTH-1:0]             count_to,
    output logic                         load,
    output logic                         count_en,
    input  logic                         done,
    output logic                         busy,
    output logic                         job_done,
    output logic [WIDTH-1:0]             job_value,
    output logic                         job_err
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_REPORT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_nxt;
    logic               r_in_ready;
    logic               w_push;
    logic               w_pop;

    logic [WD_W-1:0]    r_wd;
    logic               w_timeout;

    logic               r_load;
    logic               r_count_en;
    logic               r_busy;
    logic               r_job_done;
    logic               r_job_err;
    logic [WIDTH-1:0]   r_count_to;
    logic [WIDTH-1:0]   r_job_value;
    logic               w_load;
    logic               w_count_en;
    logic               w_busy;
    logic               w_job_done;
    logic               w_job_err;

    // FIFO: pops only happen from IDLE, so the head feeds count_to directly
    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_state == S_IDLE) && (r_level != '0);

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level    <= w_level_nxt;
            r_in_ready <= (w_level_nxt != LVL_W'(DEPTH));
        end
    end

    // Watchdog counts RUN cycles without done; SETTLE restarts it for each job
    assign w_timeout = (r_state == S_RUN) && !done && (r_wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd <= '0;
        end else if (r_state == S_SETTLE) begin
            r_wd <= '0;
        end else if ((r_state == S_RUN) && !done) begin
            r_wd <= r_wd + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_level != '0) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_RUN;
            S_RUN:    if (done || w_timeout) w_state_nxt = S_REPORT;
            S_REPORT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up with r_state
    always_comb begin
        w_load     = 1'b0;
        w_count_en = 1'b0;
        w_busy     = 1'b0;
        w_job_done = 1'b0;
        w_job_err  = 1'b0;
        w_load     = (w_state_nxt == S_LOAD);
        w_count_en = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RUN);
        w_busy     = (w_state_nxt != S_IDLE);
        w_job_done = (w_state_nxt == S_REPORT);
        w_job_err  = w_job_done && w_timeout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load      <= 1'b0;
            r_count_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_job_done  <= 1'b0;
            r_job_err   <= 1'b0;
            r_count_to  <= '0;
            r_job_value <= '0;
        end else begin
            r_load      <= w_load;
            r_count_en  <= w_count_en;
            r_busy      <= w_busy;
            r_job_done  <= w_job_done;
            r_job_err   <= w_job_err;
            r_job_value <= w_job_done ? r_count_to : '0;
            if (w_pop) begin
                r_count_to <= r_mem[r_rd_ptr];
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign level     = r_level;
    assign count_to  = r_count_to;
    assign load      = r_load;
    assign count_en  = r_count_en;
    assign busy      = r_busy;
    assign job_done  = r_job_done;
    assign job_value = r_job_value;
    assign job_err   = r_job_err;

endmodule

// File: tb/tb_count_seq.sv
// Directed bench for count_seq with a behavioural down-counter on the far side.
module tb_count_seq;

    localparam int unsigned WIDTH   = 3;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic [2:0]       level;
    logic [WIDTH-1:0] count_to;
    logic             load;
    logic             count_en;
    logic             done;
    logic             busy;
    logic             job_done;
    logic [WIDTH-1:0] job_value;
    logic             job_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [WIDTH-1:0] cnt;
    logic             stuck;
    int               dec_cnt;

    count_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .level     (level),
        .count_to  (count_to),
        .load      (load),
        .count_en  (count_en),
        .done      (done),
        .busy      (busy),
        .job_done  (job_done),
        .job_value (job_value),
        .job_err   (job_err)
    );

    always #5 clk = ~clk;

    // Counter model; stuck forces done low to exercise the watchdog
    assign done = stuck ? 1'b0 : (cnt == 3'd0);

    always @(posedge clk) begin
        if (reset) begin
            cnt     <= 3'd0;
            dec_cnt <= 0;
        end else if (load) begin
            cnt     <= count_to;
            dec_cnt <= 0;
        end else if (count_en && (cnt != 3'd0)) begin
            cnt     <= cnt - 3'd1;
            dec_cnt <= dec_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [2:0] v);
        check("push_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_value = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_burst(input logic [2:0] vals [8], input int n,
                              output int peak, output int rlow);
        int   i = 0;
        int   g = 0;
        logic acc;
        peak = 0;
        rlow = 0;
        while (i < n && g < 200) begin
            in_valid = 1'b1;
            in_value = vals[i];
            acc      = in_ready;
            if (!in_ready) begin
                rlow++;
                check("full_level", 32'(level), 32'(DEPTH));
            end
            @(negedge clk);
            g++;
            if (acc) i++;
            if (int'(level) > peak) peak = int'(level);
        end
        in_valid = 1'b0;
        check("burst_accepted", 32'(i), 32'(n));
    endtask

    // lat: LOAD cycle to job_done cycle; en: cycles with count_en high in between
    task automatic wait_job(input logic [2:0] v, input int lat, input int en, input logic err);
        int k    = 0;
        int en_n = 0;
        while (!load && k < 80) begin
            @(negedge clk);
            k++;
        end
        check("load_seen", 32'(load), 32'd1);
        check("count_to", 32'(count_to), 32'(v));
        check("load_vs_en", 32'(count_en), 32'd0);
        k = 0;
        while (!job_done && k < 80) begin
            @(negedge clk);
            k++;
            if (count_en) en_n++;
        end
        check("latency", 32'(k), 32'(lat));
        check("en_cycles", 32'(en_n), 32'(en));
        check("job_value", 32'(job_value), 32'(v));
        check("job_err", 32'(job_err), 32'(err));
        check("report_en", 32'(count_en), 32'd0);
        @(negedge clk);
        check("job_done_pulse", 32'(job_done), 32'd0);
    endtask

    initial begin
        logic [2:0] vals [8];
        int         peak;
        int         rlow;
        int         jd_n;
        int         ld_n;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_value = 3'd0;
        stuck    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count_to", 32'(count_to), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_job_done", 32'(job_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single job of 7
        push_one(3'd7);
        check("lvl_after_push", 32'(level), 32'd1);
        wait_job(3'd7, 9, 8, 1'b0);
        check("dec_7", 32'(dec_cnt), 32'd7);

        // Four consecutive pushes, no back-pressure
        vals = '{3'd7, 3'd3, 3'd5, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        fork
            push_burst(vals, 4, peak, rlow);
            begin
                wait_job(3'd7, 9, 8, 1'b0);
                wait_job(3'd3, 5, 4, 1'b0);
                wait_job(3'd5, 7, 6, 1'b0);
                wait_job(3'd1, 3, 2, 1'b0);
            end
        join
        check("peak_level", 32'(peak), 32'd3);
        check("ready_low_4", 32'(rlow), 32'd0);

        // Six pushes into a 4-deep FIFO
        vals = '{3'd2, 3'd4, 3'd6, 3'd0, 3'd3, 3'd5, 3'd0, 3'd0};
        fork
            push_burst(vals, 6, peak, rlow);
            begin
                wait_job(3'd2, 4, 3, 1'b0);
                wait_job(3'd4, 6, 5, 1'b0);
                wait_job(3'd6, 8, 7, 1'b0);
                wait_job(3'd0, 3, 2, 1'b0);
                wait_job(3'd3, 5, 4, 1'b0);
                wait_job(3'd5, 7, 6, 1'b0);
            end
        join
        check("peak_level_6", 32'(peak), 32'd4);
        check("ready_low_6", 32'(rlow), 32'd3);
        check("empty_after_6", 32'(level), 32'd0);

        // Target 0
        push_one(3'd0);
        wait_job(3'd0, 3, 2, 1'b0);
        check("dec_0", 32'(dec_cnt), 32'd0);

        // Watchdog, then a normal job
        stuck = 1'b1;
        push_one(3'd4);
        wait_job(3'd4, 14, 13, 1'b1);
        stuck = 1'b0;
        push_one(3'd2);
        wait_job(3'd2, 4, 3, 1'b0);

        // Reset mid-run with two entries queued
        push_one(3'd7);
        for (int i = 0; i < 20 && !load; i++) @(negedge clk);
        check("rst_job_load", 32'(load), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 3'd3;
        @(negedge clk);
        in_value = 3'd5;
        @(negedge clk);
        in_valid = 1'b0;
        check("queued_level", 32'(level), 32'd2);
        check("queued_busy", 32'(busy), 32'd1);
        check("queued_en", 32'(count_en), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_count_to", 32'(count_to), 32'd0);
        check("mid_rst_load", 32'(load), 32'd0);
        check("mid_rst_count_en", 32'(count_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_job_done", 32'(job_done), 32'd0);
        check("mid_rst_job_value", 32'(job_value), 32'd0);
        check("mid_rst_job_err", 32'(job_err), 32'd0);
        reset = 1'b0;
        jd_n = 0;
        ld_n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (job_done) jd_n++;
            if (load) ld_n++;
        end
        check("post_rst_job_done", 32'(jd_n), 32'd0);
        check("post_rst_load", 32'(ld_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
